// File: rtl/stripe_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// stripe_scheduler_pkg: shared constants, state encoding and feed-length helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stripe_scheduler_pkg;

  localparam int N_PE     = 64;
  localparam int QW       = 2 * N_PE;
  localparam int SW       = 14;
  localparam int MAX_COLS = 512;
  localparam int WDOG     = 2048;

  localparam logic [SW-1:0] NEG_INF = 14'b11000000000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4
  } state_e;

  function automatic logic [9:0] clamp_feed(input logic [9:0] remaining);
    return (remaining > 10'(MAX_COLS)) ? 10'(MAX_COLS) : remaining;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stripe_scheduler_watchdog.sv
// ---------------------------------------------------------------------------
// stripe_watchdog: loadable up-counter with clear, enable and terminal-count flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stripe_watchdog #(
  parameter int              WIDTH  = 12,
  parameter logic [WIDTH-1:0] TC_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] count_q, count_d;

  assign o_tc = (count_q == TC_VAL);

  // Saturates at the terminal value so the flag stays up until cleared.
  always_comb begin
    count_d = count_q;
    if (i_clr)
      count_d = '0;
    else if (i_load)
      count_d = i_load_val;
    else if (i_en && !o_tc)
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/stripe_scheduler.sv
// ---------------------------------------------------------------------------
// stripe_scheduler: sequences one banded alignment job through the PE array, stripe by stripe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stripe_scheduler
  import stripe_scheduler_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_job_valid,
  output logic          o_job_ready,
  input  logic [9:0]    i_ref_len,
  input  logic [5:0]    i_num_stripes,
  output logic [5:0]    o_qry_addr,
  input  logic [QW-1:0] i_qry_data,
  output logic [9:0]    o_ref_addr,
  input  logic [1:0]    i_ref_data,
  output logic          o_pe_start,
  output logic [1:0]    o_pe_A,
  output logic [QW-1:0] o_pe_B,
  input  logic          i_stripe_end,
  input  logic [9:0]    i_start_position,
  input  logic [SW-1:0] i_max_score_stripe,
  output logic          o_done,
  output logic          o_error,
  output logic [SW-1:0] o_best_score,
  output logic [5:0]    o_best_stripe
);

  localparam int              WD_W  = $clog2(WDOG) + 1;
  localparam logic [WD_W-1:0] WD_TC = WD_W'(WDOG - 1);

  state_e        state_q, state_d;
  logic [9:0]    ref_len_q, base_q, feed_len_q, feed_cnt_q, ref_addr_q, start_pos_q;
  logic [5:0]    num_stripes_q, stripe_q, best_stripe_q;
  logic [SW-1:0] best_q;
  logic [QW-1:0] qry_q;
  logic          ready_q, done_q, error_q;

  logic          wd_tc, accept, feed_last, stripe_hit, timeout, job_end;
  logic [10:0]   next_sum;
  logic [9:0]    remaining, feed_len_d;

  assign accept     = i_job_valid && ready_q;
  assign remaining  = ref_len_q - base_q;
  assign feed_len_d = clamp_feed(remaining);
  assign feed_last  = (feed_cnt_q == feed_len_q - 10'd1);
  assign stripe_hit = (state_q == ST_WAIT) && i_stripe_end;
  assign timeout    = (state_q == ST_WAIT) && wd_tc && !i_stripe_end;
  assign next_sum   = {1'b0, base_q} + {1'b0, start_pos_q};
  assign job_end    = (stripe_q + 6'd1 == num_stripes_q) || (next_sum >= {1'b0, ref_len_q});

  stripe_watchdog #(
    .WIDTH  (WD_W),
    .TC_VAL (WD_TC)
  ) u_watchdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (state_q != ST_WAIT),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (state_q == ST_WAIT),
    .o_tc       (wd_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FEED;
      ST_FEED:  if (feed_last) state_d = ST_WAIT;
      ST_WAIT: begin
        if (stripe_hit)   state_d = ST_NEXT;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_NEXT:  state_d = job_end ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The query word is passed straight through on the first feed cycle and held afterwards.
  always_comb begin
    o_pe_start = 1'b0;
    o_pe_A     = 2'b00;
    o_pe_B     = qry_q;
    if (state_q == ST_FEED) begin
      o_pe_start = 1'b1;
      o_pe_A     = i_ref_data;
      if (feed_cnt_q == 10'd0)
        o_pe_B = i_qry_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      ref_len_q     <= '0;
      num_stripes_q <= '0;
      base_q        <= '0;
      stripe_q      <= '0;
      feed_len_q    <= '0;
      feed_cnt_q    <= '0;
      ref_addr_q    <= '0;
      start_pos_q   <= '0;
      qry_q         <= '0;
      best_q        <= NEG_INF;
      best_stripe_q <= '0;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          ref_len_q     <= i_ref_len;
          num_stripes_q <= i_num_stripes;
          error_q       <= 1'b0;
          base_q        <= '0;
          stripe_q      <= '0;
          ref_addr_q    <= '0;
          best_q        <= NEG_INF;
          best_stripe_q <= '0;
        end
        ST_FETCH: begin
          feed_len_q <= feed_len_d;
          feed_cnt_q <= '0;
          if (feed_len_d > 10'd1)
            ref_addr_q <= ref_addr_q + 10'd1;
        end
        // Address runs one base ahead of the data and stops at the stripe's last base.
        ST_FEED: begin
          if (feed_cnt_q == 10'd0)
            qry_q <= i_qry_data;
          feed_cnt_q <= feed_cnt_q + 10'd1;
          if (feed_cnt_q + 10'd2 < feed_len_q)
            ref_addr_q <= ref_addr_q + 10'd1;
        end
        // The offset is captured with the pulse so the array need not hold it.
        ST_WAIT: begin
          if (stripe_hit) begin
            start_pos_q <= i_start_position;
            if ($signed(i_max_score_stripe) > $signed(best_q)) begin
              best_q        <= i_max_score_stripe;
              best_stripe_q <= stripe_q;
            end
          end else if (timeout) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        ST_NEXT: begin
          stripe_q   <= stripe_q + 6'd1;
          base_q     <= next_sum[9:0];
          ref_addr_q <= next_sum[9:0];
          if (job_end)
            done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_job_ready   = ready_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_best_score  = best_q;
  assign o_best_stripe = best_stripe_q;
  assign o_qry_addr    = stripe_q;
  assign o_ref_addr    = ref_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_stripe_scheduler.sv
// ---------------------------------------------------------------------------
// tb_stripe_scheduler: directed self-checking bench with buffer and PE-array models.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stripe_scheduler;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_job_valid = 1'b0;
  logic         o_job_ready;
  logic [9:0]   i_ref_len = '0;
  logic [5:0]   i_num_stripes = '0;
  logic [5:0]   o_qry_addr;
  logic [127:0] i_qry_data = '0;
  logic [9:0]   o_ref_addr;
  logic [1:0]   i_ref_data = '0;
  logic         o_pe_start;
  logic [1:0]   o_pe_A;
  logic [127:0] o_pe_B;
  logic         i_stripe_end = 1'b0;
  logic [9:0]   i_start_position = '0;
  logic [13:0]  i_max_score_stripe = '0;
  logic         o_done;
  logic         o_error;
  logic [13:0]  o_best_score;
  logic [5:0]   o_best_stripe;

  stripe_scheduler dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_job_valid        (i_job_valid),
    .o_job_ready        (o_job_ready),
    .i_ref_len          (i_ref_len),
    .i_num_stripes      (i_num_stripes),
    .o_qry_addr         (o_qry_addr),
    .i_qry_data         (i_qry_data),
    .o_ref_addr         (o_ref_addr),
    .i_ref_data         (i_ref_data),
    .o_pe_start         (o_pe_start),
    .o_pe_A             (o_pe_A),
    .o_pe_B             (o_pe_B),
    .i_stripe_end       (i_stripe_end),
    .i_start_position   (i_start_position),
    .i_max_score_stripe (i_max_score_stripe),
    .o_done             (o_done),
    .o_error            (o_error),
    .o_best_score       (o_best_score),
    .o_best_stripe      (o_best_stripe)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] ref_base(input logic [9:0] a);
    return a[1:0] ^ a[5:4] ^ {a[9], a[7]};
  endfunction

  function automatic logic [127:0] qry_word(input logic [5:0] a);
    return {16{2'b10, a}};
  endfunction

  // Buffers return data one cycle after the address.
  always @(posedge i_clk) begin
    i_ref_data <= ref_base(o_ref_addr);
    i_qry_data <= qry_word(o_qry_addr);
  end

  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // PE-array model: pulses stripe_end arr_delay cycles after o_pe_start falls.
  logic [13:0] arr_max [0:3];
  logic [9:0]  arr_pos [0:3];
  int          arr_idx = 0;
  int          arr_cnt = 0;
  int          arr_delay = 20;
  bit          arr_on = 1'b1;
  logic        arr_prev = 1'b0;

  initial forever begin
    @(posedge i_clk);
    #1;
    i_stripe_end = 1'b0;
    if (arr_cnt > 0) begin
      arr_cnt--;
      if (arr_cnt == 0 && arr_idx < 4) begin
        i_stripe_end       = 1'b1;
        i_max_score_stripe = arr_max[arr_idx];
        i_start_position   = arr_pos[arr_idx];
        arr_idx++;
      end
    end
    if (arr_prev && !o_pe_start && arr_on && !i_rst) arr_cnt = arr_delay;
    arr_prev = o_pe_start;
  end

  // Stripe monitor
  int         n_starts, data_err, done_cnt, min_gap, max_addr, gap, fall_cyc, done_cyc, mon_idx;
  int         feed_s [0:7];
  logic [9:0] base_s [0:7];
  logic [5:0] qa_s   [0:7];
  logic       mon_prev_start = 1'b0;
  logic [9:0] mon_prev_addr = '0;
  logic [5:0] mon_prev_qa = '0;

  task automatic clear_mon();
    n_starts = 0; data_err = 0; done_cnt = 0; min_gap = 1000; max_addr = 0;
    gap = 0; fall_cyc = 0; done_cyc = 0; mon_idx = 0;
  endtask

  initial forever begin
    @(negedge i_clk);
    if (o_pe_start) begin
      if (!mon_prev_start && n_starts < 8) begin
        mon_idx = n_starts;
        n_starts++;
        base_s[mon_idx] = mon_prev_addr;
        qa_s[mon_idx]   = mon_prev_qa;
        feed_s[mon_idx] = 0;
        if (n_starts > 1 && gap < min_gap) min_gap = gap;
      end
      if (o_pe_A !== ref_base(10'(int'(base_s[mon_idx]) + feed_s[mon_idx]))) data_err++;
      if (o_pe_B !== qry_word(qa_s[mon_idx])) data_err++;
      if (int'(o_ref_addr) > max_addr) max_addr = int'(o_ref_addr);
      feed_s[mon_idx]++;
      gap = 0;
    end else begin
      gap++;
    end
    if (mon_prev_start && !o_pe_start) fall_cyc = cyc;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    mon_prev_start = o_pe_start;
    mon_prev_addr  = o_ref_addr;
    mon_prev_qa    = o_qry_addr;
  end

  task automatic start_job(input logic [9:0] len, input logic [5:0] ns);
    clear_mon();
    arr_idx = 0;
    @(posedge i_clk);
    #1;
    i_ref_len     = len;
    i_num_stripes = ns;
    i_job_valid   = 1'b1;
    @(posedge i_clk);
    #1;
    i_job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_mon();
    arr_max[0] = '0; arr_max[1] = '0; arr_max[2] = '0; arr_max[3] = '0;
    arr_pos[0] = '0; arr_pos[1] = '0; arr_pos[2] = '0; arr_pos[3] = '0;

    repeat (3) @(negedge i_clk);
    check("rst_ready", o_job_ready, 1'b0);
    check("rst_best", o_best_score, 14'h3000);
    check("rst_outs", {o_done, o_error, o_pe_start, o_best_stripe, o_qry_addr, o_ref_addr}, '0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst", o_job_ready, 1'b1);

    // Single stripe
    arr_max[0] = 14'd57;
    start_job(10'd100, 6'd1);
    check("t1_busy", o_job_ready, 1'b0);
    wait_done("t1", 400);
    check("t1_feed_len", feed_s[0], 100);
    check("t1_base", base_s[0], 0);
    check("t1_addr_max", max_addr, 99);
    check("t1_data", data_err, 0);
    check("t1_done_lat", done_cyc - fall_cyc, 22);
    check("t1_best", o_best_score, 14'd57);
    check("t1_best_stripe", o_best_stripe, 6'd0);
    check("t1_ready", {o_job_ready, o_error}, 2'b10);
    repeat (3) @(negedge i_clk);
    check("t1_done_pulse", done_cnt, 1);

    // Three stripes, tie keeps the earlier stripe
    arr_max[0] = 14'd30; arr_max[1] = 14'd80; arr_max[2] = 14'd80;
    arr_pos[0] = 10'd10; arr_pos[1] = 10'd25; arr_pos[2] = 10'd0;
    start_job(10'd200, 6'd3);
    wait_done("t2", 2000);
    check("t2_stripes", n_starts, 3);
    check("t2_bases", {base_s[0], base_s[1], base_s[2]}, {10'd0, 10'd10, 10'd35});
    check("t2_qaddr", {qa_s[0], qa_s[1], qa_s[2]}, {6'd0, 6'd1, 6'd2});
    check("t2_feeds", {feed_s[0], feed_s[1], feed_s[2]}, {32'd200, 32'd190, 32'd165});
    check("t2_data", data_err, 0);
    check("t2_gap_ok", min_gap >= 2, 1'b1);
    check("t2_best", o_best_score, 14'd80);
    check("t2_best_stripe", o_best_stripe, 6'd1);

    // MAX_COLS cap
    arr_max[0] = 14'd100;
    start_job(10'd700, 6'd1);
    wait_done("t3", 2000);
    check("t3_feed_len", feed_s[0], 512);
    check("t3_addr_max", max_addr, 511);
    check("t3_data", data_err, 0);

    // Offset beyond the reference ends the job early; negative max still beats -inf
    arr_max[0] = 14'h3FFB;
    arr_pos[0] = 10'd60;
    start_job(10'd50, 6'd4);
    wait_done("t4", 500);
    repeat (10) @(negedge i_clk);
    check("t4_stripes", n_starts, 1);
    check("t4_feed_len", feed_s[0], 50);
    check("t4_best", o_best_score, 14'h3FFB);
    check("t4_best_stripe", o_best_stripe, 6'd0);

    // Watchdog abort
    arr_on = 1'b0;
    start_job(10'd30, 6'd2);
    wait_done("t5", 2300);
    check("t5_error", o_error, 1'b1);
    check("t5_wdog_lat", done_cyc - fall_cyc, 2048);
    check("t5_ready", o_job_ready, 1'b1);
    check("t5_best", o_best_score, 14'h3000);
    arr_on = 1'b1;
    repeat (3) @(negedge i_clk);
    check("t5_error_held", o_error, 1'b1);
    arr_max[0] = 14'd7;
    start_job(10'd40, 6'd1);
    @(negedge i_clk);
    check("t5_error_clear", o_error, 1'b0);
    wait_done("t5b", 500);
    check("t5b_best", o_best_score, 14'd7);

    // Reset during FEED
    arr_max[0] = 14'd12;
    start_job(10'd300, 6'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge i_clk);
        if (o_pe_start) seen = 1'b1;
      end
      check("t6_feed_seen", seen, 1'b1);
    end
    repeat (5) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_rst_outs", {o_pe_start, o_job_ready, o_done}, 3'b000);
    check("t6_rst_best", o_best_score, 14'h3000);
    repeat (3) @(negedge i_clk);
    check("t6_no_done", done_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("t6_ready", o_job_ready, 1'b1);
    start_job(10'd64, 6'd1);
    wait_done("t6b", 500);
    check("t6b_feed_len", feed_s[0], 64);
    check("t6b_data", data_err, 0);
    check("t6b_best", o_best_score, 14'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
